ppu_vga_core: RTL and testbench
===============================

PPU_VGA_CORE -- requirements
Module: ppu_vga_core

Interface
REQ-001 Parameter: CORDW, default 10, coordinate width of sx/sy.
REQ-002 clk_pix  in  1  pixel clock, all logic on rising edge.
REQ-003 sim_rst  in  1  reset, asynchronous, active-low.
REQ-004 sync  in  1  1 = parameter-load phase, 0 = run phase.
REQ-005 mode  in  3  pattern select, 0..7.
REQ-006 cfg_data  in  8  parameter byte.
REQ-007 cfg_stb  in  1  cfg_data valid.
REQ-008 cfg_ack  out  1  one-cycle acknowledge of an accepted byte.
REQ-009 pix_data  out  8  pattern pixel, RGB222 in [7:2] (R=[7:6], G=[5:4], B=[3:2]), [1:0]=0.
REQ-010 pix_stb  out  1  pix_data valid.
REQ-011 pix_ack  in  1  consumer accepts pixels; 0 blanks VGA colour.
REQ-012 vga_r, vga_g, vga_b  out  2 each  colour outputs.
REQ-013 hsync, vsync  out  1 each  sync pulses, active-low.
REQ-014 de  out  1  data enable, high in active area.
REQ-015 sx, sy  out  CORDW each  current pixel coordinates.

Function
REQ-016 Timing 640x480: sx counts 0..799 then wraps to 0; sy increments when sx wraps, counts 0..524 then wraps to 0.
REQ-017 hsync = 0 iff 656 <= sx <= 751; vsync = 0 iff 490 <= sy <= 491; de = 1 iff sx < 640 and sy < 480; all combinational from counters.
REQ-018 frame: internal 8-bit counter, increments (mod 256) on the cycle sx and sy both wrap to 0.
REQ-019 Parameter file P[0..9], 8 bits each; write pointer wptr 0..9.
REQ-020 Load: on a cycle with sync=1, cfg_stb=1, cfg_ack=0 -> P[wptr] <= cfg_data, wptr advances, cfg_ack=1 next cycle.
REQ-021 cfg_ack is high exactly one cycle per accepted byte; no capture while cfg_ack=1; max one byte per 2 cycles.
REQ-022 wptr wraps 9 -> 0; an 11th byte overwrites P[0].
REQ-023 sync=0 resets wptr to 0 next cycle; cfg_stb ignored, cfg_ack held 0.
REQ-024 Pattern value C (8 bits, evaluated on current sx, sy) by mode:
 0: P[0]; 1: P[sx/64] (index 0..9 in active area, 9 if sx >= 640);
 2: P[band], band = sy/48 clamped to 9; 3: sx[5]^sy[5] ? P[1] : P[2];
 4: (sx[7:0] ^ sy[7:0]) ^ P[9]; 5: sx[7:0] + frame;
 6: P[4] if sx==0, sx==639, sy==0 or sy==479, else P[5]; 7: sx[7:0] + sy[7:0] + P[6].
REQ-025 All sums mod 256, no saturation.
REQ-026 pix_data <= {C[7:2], 2'b00} each cycle when sync=0, else 8'h00; 1-cycle latency.
REQ-027 pix_stb <= (sync==0) and de, registered alongside pix_data.
REQ-028 de_q = de delayed one cycle; {vga_r,vga_g,vga_b} = pix_data[7:2] when de_q=1, pix_stb=1 and pix_ack=1, else all 0 (combinational).
REQ-029 mode and sync are sampled every cycle; a change takes effect on the next pix_data update with no frame resync.
REQ-030 Timing counters run continuously in both phases, independent of sync and handshake.

Reset
REQ-031 sim_rst low asynchronously clears sx, sy, frame, wptr, P[0..9], pix_data, pix_stb, de_q and cfg_ack to 0.
REQ-032 During reset: hsync=1, vsync=1, de=1 (coordinates 0,0), vga colour 0.
REQ-033 Reset release mid-load restarts the load at P[0]; mid-frame restarts timing at (0,0).

Verification
REQ-034 Timing: free run after reset -> hsync low for sx 656..751 (96 clocks), vsync low for lines 490..491, frame period 420000 clocks, de high 640x480 per frame.
REQ-035 Load: sync=1, stb held, bytes 42,123,87,255,0,198,76,34,210,0xB6 advanced on each ack -> 10 acks, each 1 cycle wide, P[0..9] equal the bytes.
REQ-036 Mode 4 after load, pix_ack=1: at (sx=3, sy=5), one cycle later pix_data = ((3^5)^0xB6) & 0xFC = 0xB0, vga_r=2, vga_g=3, vga_b=0.
REQ-037 Mode 1: sx=64 -> pix_data = 123 & 0xFC = 0x78; sx=700 -> colour 0 (blanking).
REQ-038 pix_ack=0 or sync=1 -> vga colour 0 all active pixels; 11th byte -> P[0] overwritten, wptr=1.
REQ-039 Assert sim_rst mid-frame -> sx, sy, P, pix_data immediately 0; cfg_ack 0.

Source files
------------

// File: rtl/ppu_vga_core.sv
// ppu_vga_core: 640x480 VGA timing generator with a ten-byte parameter file
// loaded over a cfg_stb/cfg_ack handshake and eight selectable test patterns.
// Pattern pixels are registered once (1-cycle latency) and gated onto the
// colour outputs only when the delayed data enable and the consumer agree.
module ppu_vga_core #(
  parameter int CORDW = 10
) (
  input  logic             clk_pix,
  input  logic             sim_rst,
  input  logic             sync,
  input  logic [2:0]       mode,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_stb,
  output logic             cfg_ack,
  output logic [7:0]       pix_data,
  output logic             pix_stb,
  input  logic             pix_ack,
  output logic [1:0]       vga_r,
  output logic [1:0]       vga_g,
  output logic [1:0]       vga_b,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy
);

  localparam int H_ACT  = 640;
  localparam int H_SS   = 656;
  localparam int H_SE   = 751;
  localparam int H_LAST = 799;
  localparam int V_ACT  = 480;
  localparam int V_SS   = 490;
  localparam int V_SE   = 491;
  localparam int V_LAST = 524;
  localparam int NPARAM = 10;

  logic [CORDW-1:0] sx_reg, sy_reg;
  logic [7:0]       frame_reg;
  logic             line_end, frame_end;

  logic [3:0]       wptr_reg;
  logic [7:0]       p_reg [0:NPARAM-1];
  logic             cfg_ack_reg;
  logic             accept;

  logic [CORDW-1:0] sx_div, sy_div;
  logic [3:0]       col_idx, band_idx;
  logic             border;
  logic [7:0]       pat;

  logic [7:0]       pix_data_reg;
  logic             pix_stb_reg;
  logic             de_q_reg;

  assign line_end  = (sx_reg == CORDW'(H_LAST));
  assign frame_end = line_end && (sy_reg == CORDW'(V_LAST));

  // Raster counters: run free in every phase, wrap at end of line / frame.
  always_ff @(posedge clk_pix or negedge sim_rst) begin
    if (!sim_rst) begin
      sx_reg <= '0;
      sy_reg <= '0;
    end else if (line_end) begin
      sx_reg <= '0;
      sy_reg <= frame_end ? '0 : sy_reg + CORDW'(1);
    end else begin
      sx_reg <= sx_reg + CORDW'(1);
    end
  end

  // Frame counter advances on the single cycle both coordinates wrap.
  always_ff @(posedge clk_pix or negedge sim_rst) begin
    if (!sim_rst)       frame_reg <= 8'd0;
    else if (frame_end) frame_reg <= frame_reg + 8'd1;
  end

  assign hsync = ~((sx_reg >= CORDW'(H_SS)) && (sx_reg <= CORDW'(H_SE)));
  assign vsync = ~((sy_reg >= CORDW'(V_SS)) && (sy_reg <= CORDW'(V_SE)));
  assign de    = (sx_reg < CORDW'(H_ACT)) && (sy_reg < CORDW'(V_ACT));
  assign sx    = sx_reg;
  assign sy    = sy_reg;

  // A byte is taken only while the previous ack is low, so bytes arrive at
  // most every other cycle and a held strobe cannot double-capture.
  assign accept = sync && cfg_stb && !cfg_ack_reg;

  // Parameter file load; leaving the load phase rewinds the write pointer.
  always_ff @(posedge clk_pix or negedge sim_rst) begin
    if (!sim_rst) begin
      wptr_reg    <= 4'd0;
      cfg_ack_reg <= 1'b0;
      for (int i = 0; i < NPARAM; i++) p_reg[i] <= 8'd0;
    end else if (!sync) begin
      wptr_reg    <= 4'd0;
      cfg_ack_reg <= 1'b0;
    end else begin
      cfg_ack_reg <= accept;
      if (accept) begin
        p_reg[wptr_reg] <= cfg_data;
        wptr_reg        <= (wptr_reg == 4'(NPARAM - 1)) ? 4'd0 : wptr_reg + 4'd1;
      end
    end
  end

  assign cfg_ack = cfg_ack_reg;

  assign sx_div = sx_reg >> 6;
  assign sy_div = sy_reg / CORDW'(48);

  // Pattern generator; column and band indices saturate at the last entry.
  always_comb begin
    col_idx  = (sx_div > CORDW'(9)) ? 4'd9 : sx_div[3:0];
    band_idx = (sy_div > CORDW'(9)) ? 4'd9 : sy_div[3:0];
    border   = (sx_reg == '0) || (sx_reg == CORDW'(H_ACT - 1)) ||
               (sy_reg == '0) || (sy_reg == CORDW'(V_ACT - 1));
    pat      = 8'd0;
    case (mode)
      3'd0: pat = p_reg[0];
      3'd1: pat = p_reg[col_idx];
      3'd2: pat = p_reg[band_idx];
      3'd3: pat = (sx_reg[5] ^ sy_reg[5]) ? p_reg[1] : p_reg[2];
      3'd4: pat = (sx_reg[7:0] ^ sy_reg[7:0]) ^ p_reg[9];
      3'd5: pat = sx_reg[7:0] + frame_reg;
      3'd6: pat = border ? p_reg[4] : p_reg[5];
      3'd7: pat = sx_reg[7:0] + sy_reg[7:0] + p_reg[6];
      default: pat = 8'd0;
    endcase
  end

  // Pixel output stage: one cycle behind the counters, muted in load phase.
  always_ff @(posedge clk_pix or negedge sim_rst) begin
    if (!sim_rst) begin
      pix_data_reg <= 8'd0;
      pix_stb_reg  <= 1'b0;
      de_q_reg     <= 1'b0;
    end else begin
      pix_data_reg <= sync ? 8'd0 : (pat & 8'hFC);
      pix_stb_reg  <= !sync && de;
      de_q_reg     <= de;
    end
  end

  assign pix_data = pix_data_reg;
  assign pix_stb  = pix_stb_reg;
  assign {vga_r, vga_g, vga_b} = (de_q_reg && pix_stb_reg && pix_ack) ?
                                 pix_data_reg[7:2] : 6'd0;

endmodule

// File: tb/tb_ppu_vga_core.sv
// Directed bench for ppu_vga_core: reset state, raster timing on the first
// lines, parameter load handshake, pattern modes, blanking and async reset.
module tb_ppu_vga_core;

  logic       clk_pix = 1'b0;
  logic       sim_rst, sync, cfg_stb, cfg_ack, pix_stb, pix_ack;
  logic       hsync, vsync, de;
  logic [2:0] mode;
  logic [7:0] cfg_data, pix_data;
  logic [1:0] vga_r, vga_g, vga_b;
  logic [9:0] sx, sy;

  int checks = 0;
  int errors = 0;

  logic [7:0] load_bytes [0:9];
  int         px    [0:6];
  int         pmode [0:6];
  logic [7:0] pexp  [0:6];

  ppu_vga_core #(.CORDW(10)) dut (
    .clk_pix (clk_pix),
    .sim_rst (sim_rst),
    .sync    (sync),
    .mode    (mode),
    .cfg_data(cfg_data),
    .cfg_stb (cfg_stb),
    .cfg_ack (cfg_ack),
    .pix_data(pix_data),
    .pix_stb (pix_stb),
    .pix_ack (pix_ack),
    .vga_r   (vga_r),
    .vga_g   (vga_g),
    .vga_b   (vga_b),
    .hsync   (hsync),
    .vsync   (vsync),
    .de      (de),
    .sx      (sx),
    .sy      (sy)
  );

  always #5 clk_pix = ~clk_pix;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance on falling edges until the raster reaches (x, y); y < 0 = any line.
  task automatic wait_at(input int x, input int y);
    int n;
    n = 0;
    while (!((int'(sx) == x) && (y < 0 || int'(sy) == y)) && n < 10000) begin
      @(negedge clk_pix);
      n++;
    end
    if (n >= 10000) begin
      checks++;
      errors++;
      $error("FAIL wait_at observed timeout expected sx=%0d sy=%0d", x, y);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    cfg_data = b;
    cfg_stb  = 1'b1;
    n = 0;
    while (cfg_ack !== 1'b1 && n < 20) begin
      @(negedge clk_pix);
      n++;
    end
    check("send_ack", cfg_ack, 1);
    cfg_stb = 1'b0;
    @(negedge clk_pix);
  endtask

  initial begin
    int n, acks;
    load_bytes = '{8'd42, 8'd123, 8'd87, 8'd255, 8'd0, 8'd198, 8'd76, 8'd34, 8'd210, 8'hB6};
    px    = '{0, 1, 3, 10, 20, 32, 50};
    pmode = '{6, 6, 4, 7, 5, 3, 2};
    pexp  = '{8'h00, 8'hC4, 8'hB0, 8'h58, 8'h14, 8'h98, 8'h40};

    sim_rst = 1'b1; sync = 1'b1; mode = 3'd0; cfg_data = 8'd0; cfg_stb = 1'b0; pix_ack = 1'b0;
    #2 sim_rst = 1'b0;
    #21;
    check("rst_sx", sx, 0);
    check("rst_sy", sy, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 1);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_stb", pix_stb, 0);
    check("rst_cfg_ack", cfg_ack, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    @(negedge clk_pix);
    sim_rst = 1'b1;

    // Horizontal timing on line 0
    wait_at(639, 0);
    check("de_at_639", de, 1);
    @(negedge clk_pix);
    check("de_at_640", de, 0);
    wait_at(655, 0);
    check("hsync_at_655", hsync, 1);
    @(negedge clk_pix);
    check("hsync_at_656", hsync, 0);
    n = 0;
    while (hsync === 1'b0 && n < 200) begin
      n++;
      @(negedge clk_pix);
    end
    check("hsync_width", n, 96);
    check("hsync_end_sx", sx, 752);
    check("vsync_line0", vsync, 1);
    wait_at(799, 0);
    @(negedge clk_pix);
    check("wrap_sx", sx, 0);
    check("wrap_sy", sy, 1);

    // Load ten bytes with the strobe held, advancing data on each ack
    acks = 0;
    cfg_data = load_bytes[0];
    cfg_stb  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (cfg_ack !== 1'b1 && n < 20) begin
        @(negedge clk_pix);
        n++;
      end
      if (cfg_ack === 1'b1) acks++;
      if (i < 9) cfg_data = load_bytes[i+1];
      else       cfg_stb  = 1'b0;
      @(negedge clk_pix);
      check($sformatf("ack_width_%0d", i), cfg_ack, 0);
    end
    check("ack_count", acks, 10);

    // Mode 1 columns on line 2 expose every parameter byte
    sync = 1'b0; mode = 3'd1; pix_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_at(64 * i, 2);
      @(negedge clk_pix);
      check($sformatf("m1_pix_%0d", i), pix_data, load_bytes[i] & 8'hFC);
      check($sformatf("m1_rgb_%0d", i), {vga_r, vga_g, vga_b}, load_bytes[i][7:2]);
    end
    wait_at(700, 2);
    @(negedge clk_pix);
    check("m1_700_pix", pix_data, 8'hB4);
    check("m1_700_stb", pix_stb, 0);
    check("m1_700_rgb", {vga_r, vga_g, vga_b}, 0);

    // 11th byte wraps to P[0], 12th lands in P[1]
    sync = 1'b1;
    send(8'h11);
    send(8'h99);
    sync = 1'b0; mode = 3'd0;
    @(negedge clk_pix);
    check("p0_overwrite", pix_data, 8'h10);
    mode = 3'd1;
    wait_at(100, -1);
    @(negedge clk_pix);
    check("p1_overwrite", pix_data, 8'h98);
    wait_at(130, -1);
    @(negedge clk_pix);
    check("p2_kept", pix_data, 8'h54);

    // Strobe ignored in run phase; re-entering load restarts at P[0]
    cfg_data = 8'h77; cfg_stb = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk_pix);
      if (cfg_ack !== 1'b0) n++;
    end
    check("ack_in_run", n, 0);
    cfg_stb = 1'b0;
    sync = 1'b1;
    send(8'h40);
    sync = 1'b0; mode = 3'd0;
    @(negedge clk_pix);
    check("wptr_restart", pix_data, 8'h40);

    // Blanking: load phase, then consumer not accepting
    sync = 1'b1; pix_ack = 1'b1;
    wait_at(200, -1);
    @(negedge clk_pix);
    check("sync_pix", pix_data, 0);
    check("sync_stb", pix_stb, 0);
    check("sync_rgb", {vga_r, vga_g, vga_b}, 0);
    sync = 1'b0; pix_ack = 1'b0;
    wait_at(300, -1);
    @(negedge clk_pix);
    check("nack_pix", pix_data, 8'h40);
    check("nack_stb", pix_stb, 1);
    check("nack_rgb", {vga_r, vga_g, vga_b}, 0);
    pix_ack = 1'b1;
    #1;
    check("ack_rgb", {vga_r, vga_g, vga_b}, 6'h10);

    // Assorted modes on line 5, switching mode between pixels
    for (int i = 0; i < 7; i++) begin
      wait_at(px[i], 5);
      mode = pmode[i][2:0];
      @(negedge clk_pix);
      check($sformatf("mode%0d_x%0d", pmode[i], px[i]), pix_data, pexp[i]);
      if (pmode[i] == 4) begin
        check("m4_r", vga_r, 2);
        check("m4_g", vga_g, 3);
        check("m4_b", vga_b, 0);
      end
    end

    // Asynchronous reset mid-frame while a pixel is being shown
    @(negedge clk_pix);
    check("pre_rst_pix", pix_data, 8'h40);
    sim_rst = 1'b0;
    #1;
    check("arst_sx", sx, 0);
    check("arst_sy", sy, 0);
    check("arst_pix", pix_data, 0);
    check("arst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("arst_hsync", hsync, 1);
    check("arst_de", de, 1);
    @(negedge clk_pix);
    sim_rst = 1'b1; sync = 1'b0; mode = 3'd0;
    @(negedge clk_pix);
    check("restart_sx", sx, 1);
    check("p_cleared", pix_data, 0);

    // Asynchronous reset mid-load: ack drops at once, load restarts at P[0]
    sync = 1'b1;
    cfg_data = 8'h55; cfg_stb = 1'b1;
    n = 0;
    while (cfg_ack !== 1'b1 && n < 20) begin
      @(negedge clk_pix);
      n++;
    end
    check("load_ack", cfg_ack, 1);
    sim_rst = 1'b0;
    #1;
    check("arst_ack", cfg_ack, 0);
    cfg_stb = 1'b0;
    @(negedge clk_pix);
    sim_rst = 1'b1;
    send(8'h84);
    sync = 1'b0; mode = 3'd0;
    @(negedge clk_pix);
    check("reload_p0", pix_data, 8'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
